pe_array_cfg_seq: RTL and testbench

PE_ARRAY_CFG_SEQ -- requirements
Module: pe_array_cfg_seq

---
 rtl/pe_array_cfg_seq_pkg.sv | 18 +
 rtl/pe_array_cfg_seq_if.sv | 24 ++
 rtl/pe_array_cfg_seq.sv | 109 ++++++++++
 tb/tb_pe_array_cfg_seq.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pe_array_cfg_seq_pkg.sv
// Shared constants for the PE-array configuration sequencer: payload width,
// the idle select code and the sequencer state encoding.
package pe_array_cfg_seq_pkg;

    localparam int unsigned PE_INST = 16;

    // pe_sel == 3'b111 addresses no element, so this select leaves the array untouched
    localparam logic [4:0] IDLE_SEL = 5'b00111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_RUN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/pe_array_cfg_seq_if.sv
// Config-memory read port: the sequencer issues ren/addr, and the memory
// returns the entry on cfg_rdata one cycle later.
interface pe_array_cfg_seq_if #(
    parameter int unsigned CFG_AW = 8
);
    import pe_array_cfg_seq_pkg::*;

    logic              cfg_ren;
    logic [CFG_AW-1:0] cfg_addr;
    logic [PE_INST+4:0] cfg_rdata;

    modport master (
        output cfg_ren,
        output cfg_addr,
        input  cfg_rdata
    );

    modport slave (
        input  cfg_ren,
        input  cfg_addr,
        output cfg_rdata
    );

endinterface

// File: rtl/pe_array_cfg_seq.sv
// Loads cfg_count entries from config memory into the PE array, two cycles per
// entry, then drives one run select for run_cycles cycles and pulses done.
module pe_array_cfg_seq
    import pe_array_cfg_seq_pkg::*;
#(
    parameter int unsigned CFG_AW = 8,
    parameter int unsigned RUN_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [CFG_AW-1:0]   cfg_base,
    input  logic [CFG_AW-1:0]   cfg_count,
    input  logic [4:0]          run_target,
    input  logic [RUN_W-1:0]    run_cycles,
    pe_array_cfg_seq_if.master  cfg,
    output logic [4:0]          init_PE_array,
    output logic [PE_INST-1:0]  pe_config,
    output logic [4:0]          run_PE_array,
    output logic                busy,
    output logic                done
);

    state_e              state, state_n;
    logic [CFG_AW-1:0]   ent_cnt;
    logic [CFG_AW-1:0]   ptr;
    logic [RUN_W-1:0]    run_cnt;
    logic [4:0]          run_tgt;
    logic [PE_INST-1:0]  pe_cfg_q;
    logic                accept;

    assign accept = start && !abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            ent_cnt  <= '0;
            ptr      <= '0;
            run_cnt  <= '0;
            run_tgt  <= IDLE_SEL;
            pe_cfg_q <= '0;
        end else begin
            state <= state_n;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        ent_cnt <= cfg_count;
                        ptr     <= cfg_base;
                        run_cnt <= run_cycles;
                        run_tgt <= run_target;
                    end
                end
                ST_LOAD: begin
                    ptr      <= ptr + CFG_AW'(1);
                    ent_cnt  <= ent_cnt - CFG_AW'(1);
                    pe_cfg_q <= cfg.cfg_rdata[PE_INST-1:0];
                end
                ST_RUN:  run_cnt <= run_cnt - RUN_W'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n       = state;
        cfg.cfg_ren   = 1'b0;
        cfg.cfg_addr  = ptr;
        init_PE_array = IDLE_SEL;
        pe_config     = pe_cfg_q;
        run_PE_array  = IDLE_SEL;
        busy          = (state != ST_IDLE);
        done          = 1'b0;

        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (cfg_count != '0)       state_n = ST_FETCH;
                    else if (run_cycles != '0) state_n = ST_RUN;
                    else                       state_n = ST_DONE;
                end
            end
            ST_FETCH: begin
                cfg.cfg_ren = 1'b1;
                state_n     = ST_LOAD;
            end
            ST_LOAD: begin
                // rdata is the entry fetched in the previous cycle; forward it straight through
                init_PE_array = cfg.cfg_rdata[PE_INST+4 -: 5];
                pe_config     = cfg.cfg_rdata[PE_INST-1:0];
                if (ent_cnt > CFG_AW'(1))  state_n = ST_FETCH;
                else if (run_cnt != '0)    state_n = ST_RUN;
                else                       state_n = ST_DONE;
            end
            ST_RUN: begin
                run_PE_array = run_tgt;
                if (run_cnt <= RUN_W'(1)) state_n = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase

        if (abort && state != ST_IDLE) state_n = ST_IDLE;
    end

endmodule

// File: tb/tb_pe_array_cfg_seq.sv
// Randomised bench for pe_array_cfg_seq: expected per-cycle outputs are derived
// from the sequence timeline (2 cycles per entry, then run, then done).
module tb_pe_array_cfg_seq;
    import pe_array_cfg_seq_pkg::*;

    localparam int unsigned CFG_AW = 8;
    localparam int unsigned RUN_W  = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
    logic                abort = 1'b0;
    logic [CFG_AW-1:0]   cfg_base = '0;
    logic [CFG_AW-1:0]   cfg_count = '0;
    logic [4:0]          run_target = '0;
    logic [RUN_W-1:0]    run_cycles = '0;
    logic [4:0]          init_PE_array;
    logic [PE_INST-1:0]  pe_config;
    logic [4:0]          run_PE_array;
    logic                busy;
    logic                done;

    always #5 clk = ~clk;

    pe_array_cfg_seq_if #(.CFG_AW(CFG_AW)) cif ();

    pe_array_cfg_seq #(
        .CFG_AW(CFG_AW),
        .RUN_W (RUN_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .cfg_base     (cfg_base),
        .cfg_count    (cfg_count),
        .run_target   (run_target),
        .run_cycles   (run_cycles),
        .cfg          (cif),
        .init_PE_array(init_PE_array),
        .pe_config    (pe_config),
        .run_PE_array (run_PE_array),
        .busy         (busy),
        .done         (done)
    );

    logic [PE_INST+4:0] mem [256];

    always @(posedge clk) begin
        if (cif.cfg_ren) cif.cfg_rdata <= mem[cif.cfg_addr];
    end

    int unsigned        n_cmp = 0;
    int unsigned        n_bad = 0;
    logic [PE_INST-1:0] exp_pecfg = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input string where, input bit ren, input bit addr_chk,
                                 input logic [7:0] addr, input logic [4:0] init,
                                 input logic [4:0] run, input bit busy_e, input bit done_e);
        check_eq({where, ".cfg_ren"}, 32'(cif.cfg_ren), 32'(ren));
        if (addr_chk) check_eq({where, ".cfg_addr"}, 32'(cif.cfg_addr), 32'(addr));
        check_eq({where, ".init"}, 32'(init_PE_array), 32'(init));
        check_eq({where, ".pe_config"}, 32'(pe_config), 32'(exp_pecfg));
        check_eq({where, ".run"}, 32'(run_PE_array), 32'(run));
        check_eq({where, ".busy"}, 32'(busy), 32'(busy_e));
        check_eq({where, ".done"}, 32'(done), 32'(done_e));
    endtask

    task automatic check_idle(input string where);
        check_outputs(where, 1'b0, 1'b0, 8'h00, IDLE_SEL, IDLE_SEL, 1'b0, 1'b0);
    endtask

    // One sequence; abort_k / restart_k name the cycle (1 = first after start) in
    // which abort or a spurious start is driven, 0 means never.
    task automatic run_seq(input logic [7:0] base, input logic [7:0] cnt, input logic [15:0] rc,
                           input logic [4:0] tgt, input int abort_k, input int restart_k);
        int n;
        int r;
        int total;
        bit aborted;
        n = int'(cnt);
        r = int'(rc);
        total = 2 * n + r + 1;
        aborted = 1'b0;
        @(negedge clk);
        cfg_base = base; cfg_count = cnt; run_cycles = rc; run_target = tgt; start = 1'b1;
        for (int k = 1; k <= total && !aborted; k++) begin
            bit         ren;
            bit         dn;
            logic [7:0] a;
            logic [4:0] init;
            logic [4:0] run;
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            ren = 1'b0; dn = 1'b0; a = 8'h00; init = IDLE_SEL; run = IDLE_SEL;
            if (k <= 2 * n) begin
                a = base + 8'((k - 1) / 2);
                if (k % 2 == 1) ren = 1'b1;
                else begin
                    init = mem[a][PE_INST+4 -: 5];
                    exp_pecfg = mem[a][PE_INST-1:0];
                end
            end else if (k <= 2 * n + r) begin
                run = tgt;
            end else begin
                dn = 1'b1;
            end
            check_outputs($sformatf("seq.c%0d", k), ren, ren, a, init, run, 1'b1, dn);
            // changing the inputs mid-sequence must not disturb the latched copy
            if (k == 1) begin
                cfg_base = 8'($urandom); cfg_count = 8'($urandom);
                run_cycles = 16'($urandom); run_target = 5'($urandom);
            end
            if (k == restart_k) start = 1'b1;
            if (k == abort_k) begin
                abort = 1'b1;
                aborted = 1'b1;
            end
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            check_idle($sformatf("post%0d", i));
        end
    endtask

    task automatic reset_mid_run();
        @(negedge clk);
        cfg_base = 8'h10; cfg_count = 8'd1; run_cycles = 16'd8; run_target = 5'b10010; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 2; k <= 4; k++) @(negedge clk);
        exp_pecfg = mem[8'h10][PE_INST-1:0];
        check_eq("rstmid.run_active", 32'(run_PE_array), 32'(5'b10010));
        #1 rst = 1'b0;
        #1;
        exp_pecfg = '0;
        check_outputs("rstasync", 1'b0, 1'b1, 8'h00, IDLE_SEL, IDLE_SEL, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check_idle($sformatf("rstpost%0d", i));
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = (PE_INST + 5)'({$urandom, $urandom});
        #1;
        check_outputs("reset", 1'b0, 1'b1, 8'h00, IDLE_SEL, IDLE_SEL, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle("idle0");

        run_seq(8'hFE, 8'd3, 16'd4, 5'b01010, 0, 0);   // address wrap FE,FF,00
        run_seq(8'h40, 8'd0, 16'd0, 5'b11000, 0, 0);   // empty sequence
        run_seq(8'h20, 8'd4, 16'd5, 5'b00001, 4, 0);   // abort in second LOAD
        run_seq(8'h33, 8'd2, 16'd6, 5'b01101, 0, 7);   // start re-pulsed during RUN
        run_seq(8'h50, 8'd1, 16'd2, 5'b10100, 0, 5);   // start in the DONE cycle
        run_seq(8'h60, 8'd0, 16'd3, 5'b00010, 0, 0);   // run only
        run_seq(8'h70, 8'd2, 16'd0, 5'b00011, 0, 0);   // load only
        run_seq(8'h80, 8'd2, 16'd3, 5'b00100, 3, 3);   // abort beats start
        reset_mid_run();

        for (int t = 0; t < 25; t++) begin
            logic [7:0]  b;
            logic [7:0]  c;
            logic [15:0] rc;
            logic [4:0]  tg;
            int          total;
            int          ak;
            int          sk;
            b  = 8'($urandom);
            c  = 8'($urandom_range(0, 5));
            rc = 16'($urandom_range(0, 6));
            tg = 5'($urandom);
            total = 2 * int'(c) + int'(rc) + 1;
            ak = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, total)) : 0;
            sk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, total)) : 0;
            run_seq(b, c, rc, tg, ak, sk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
